// File: rtl/data_bus_controller_pkg.sv
// Memory map and shared types for the CPU data-bus controller.
package bus_pkg;

    localparam logic [31:0] ROM_BASE        = 32'h0000_0000;
    localparam int          ROM_ADDR_WIDTH  = 12;
    localparam logic [31:0] RAM_BASE        = 32'h1000_0000;
    localparam int          RAM_ADDR_WIDTH  = 14;
    localparam logic [31:0] UART_BASE       = 32'h2000_0000;
    localparam int          UART_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ROM,
        SEL_RAM,
        SEL_UART
    } bus_sel_t;

    // Local error responder: idle, or acking an unmapped/illegal access.
    typedef enum logic {
        ERR_IDLE,
        ERR_ACK
    } err_st_t;

endpackage

// File: rtl/data_bus_controller_if.sv
// Bus interfaces: the CPU-facing port (carries an error flag) and the
// slave-facing port (byte-offset address of parameterizable width).
interface cpu_bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (output req, we, addr, wdata, be, input  rdata, ready, err);
    modport slave  (input  req, we, addr, wdata, be, output rdata, ready, err);
endinterface

interface slv_bus_if #(parameter int AW = 32);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic [31:0]   rdata;
    logic          ready;

    modport master (output req, we, addr, wdata, be, input  rdata, ready);
    modport slave  (input  req, we, addr, wdata, be, output rdata, ready);
endinterface

// File: rtl/data_bus_controller_bus_addr_decoder.sv
// Pure combinational address decode: which slave window is hit, the
// base-relative offsets for each window, and a flag for writes to ROM.
module bus_addr_decoder #(
    parameter logic [31:0] ROM_BASE        = bus_pkg::ROM_BASE,
    parameter int          ROM_ADDR_WIDTH  = bus_pkg::ROM_ADDR_WIDTH,
    parameter logic [31:0] RAM_BASE        = bus_pkg::RAM_BASE,
    parameter int          RAM_ADDR_WIDTH  = bus_pkg::RAM_ADDR_WIDTH,
    parameter logic [31:0] UART_BASE       = bus_pkg::UART_BASE,
    parameter int          UART_ADDR_WIDTH = bus_pkg::UART_ADDR_WIDTH
) (
    input  logic [31:0]                i_addr,
    input  logic                       i_we,
    output bus_pkg::bus_sel_t          o_sel,
    output logic                       o_rom_wr,
    output logic [ROM_ADDR_WIDTH-1:0]  o_rom_off,
    output logic [RAM_ADDR_WIDTH-1:0]  o_ram_off,
    output logic [UART_ADDR_WIDTH-1:0] o_uart_off
);
    import bus_pkg::*;

    logic w_hit_rom, w_hit_ram, w_hit_uart;

    assign w_hit_rom  = (i_addr[31:ROM_ADDR_WIDTH]  == ROM_BASE[31:ROM_ADDR_WIDTH]);
    assign w_hit_ram  = (i_addr[31:RAM_ADDR_WIDTH]  == RAM_BASE[31:RAM_ADDR_WIDTH]);
    assign w_hit_uart = (i_addr[31:UART_ADDR_WIDTH] == UART_BASE[31:UART_ADDR_WIDTH]);

    assign o_rom_off  = i_addr[ROM_ADDR_WIDTH-1:0];
    assign o_ram_off  = i_addr[RAM_ADDR_WIDTH-1:0];
    assign o_uart_off = i_addr[UART_ADDR_WIDTH-1:0];

    // Windows do not overlap, so the priority order here is irrelevant.
    always_comb begin
        o_sel = SEL_NONE;
        if (w_hit_rom)       o_sel = SEL_ROM;
        else if (w_hit_ram)  o_sel = SEL_RAM;
        else if (w_hit_uart) o_sel = SEL_UART;
    end

    assign o_rom_wr = w_hit_rom & i_we;

endmodule

// File: rtl/data_bus_controller.sv
// Routes the core's data port to ROM / RAM / UART, muxes the response back,
// and answers unmapped accesses and ROM writes with a one-cycle error ack.
module data_bus_controller #(
    parameter logic [31:0] ROM_BASE        = bus_pkg::ROM_BASE,
    parameter int          ROM_ADDR_WIDTH  = bus_pkg::ROM_ADDR_WIDTH,
    parameter logic [31:0] RAM_BASE        = bus_pkg::RAM_BASE,
    parameter int          RAM_ADDR_WIDTH  = bus_pkg::RAM_ADDR_WIDTH,
    parameter logic [31:0] UART_BASE       = bus_pkg::UART_BASE,
    parameter int          UART_ADDR_WIDTH = bus_pkg::UART_ADDR_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    cpu_bus_if.slave   cpu,
    slv_bus_if.master  rom,
    slv_bus_if.master  ram,
    slv_bus_if.master  uart
);
    import bus_pkg::*;

    bus_sel_t                   w_sel;
    logic                       w_rom_wr;
    logic                       w_bad;
    logic [ROM_ADDR_WIDTH-1:0]  w_rom_off;
    logic [RAM_ADDR_WIDTH-1:0]  w_ram_off;
    logic [UART_ADDR_WIDTH-1:0] w_uart_off;
    err_st_t                    r_err_st;
    err_st_t                    w_err_nxt;

    bus_addr_decoder #(
        .ROM_BASE        (ROM_BASE),
        .ROM_ADDR_WIDTH  (ROM_ADDR_WIDTH),
        .RAM_BASE        (RAM_BASE),
        .RAM_ADDR_WIDTH  (RAM_ADDR_WIDTH),
        .UART_BASE       (UART_BASE),
        .UART_ADDR_WIDTH (UART_ADDR_WIDTH)
    ) u_dec (
        .i_addr     (cpu.addr),
        .i_we       (cpu.we),
        .o_sel      (w_sel),
        .o_rom_wr   (w_rom_wr),
        .o_rom_off  (w_rom_off),
        .o_ram_off  (w_ram_off),
        .o_uart_off (w_uart_off)
    );

    // Request forwarding; ROM writes are never forwarded.
    assign rom.req   = cpu.req & rst_n & (w_sel == SEL_ROM) & ~cpu.we;
    assign ram.req   = cpu.req & rst_n & (w_sel == SEL_RAM);
    assign uart.req  = cpu.req & rst_n & (w_sel == SEL_UART);

    assign rom.addr  = w_rom_off;
    assign ram.addr  = w_ram_off;
    assign uart.addr = w_uart_off;

    assign rom.we    = cpu.we;
    assign ram.we    = cpu.we;
    assign uart.we   = cpu.we;
    assign rom.wdata = cpu.wdata;
    assign ram.wdata = cpu.wdata;
    assign uart.wdata = cpu.wdata;
    assign rom.be    = cpu.be;
    assign ram.be    = cpu.be;
    assign uart.be   = cpu.be;

    assign w_bad = cpu.req & rst_n & ((w_sel == SEL_NONE) | w_rom_wr);

    // Error responder state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err_st <= ERR_IDLE;
        else        r_err_st <= w_err_nxt;
    end

    // Ack a bad access once, the cycle after it is seen; never back-to-back.
    always_comb begin
        w_err_nxt = ERR_IDLE;
        if (r_err_st == ERR_IDLE && w_bad) w_err_nxt = ERR_ACK;
    end

    // Response mux: local error ack wins, else the selected slave's response.
    always_comb begin
        cpu.ready = 1'b0;
        cpu.err   = 1'b0;
        cpu.rdata = 32'h0;
        if (!rst_n) begin
            cpu.ready = 1'b0;
        end else if (r_err_st == ERR_ACK) begin
            cpu.ready = 1'b1;
            cpu.err   = 1'b1;
        end else if (cpu.req) begin
            case (w_sel)
                SEL_ROM: if (!w_rom_wr && rom.ready) begin
                    cpu.ready = 1'b1;
                    cpu.rdata = rom.rdata;
                end
                SEL_RAM: if (ram.ready) begin
                    cpu.ready = 1'b1;
                    cpu.rdata = ram.rdata;
                end
                SEL_UART: if (uart.ready) begin
                    cpu.ready = 1'b1;
                    cpu.rdata = uart.rdata;
                end
                default: cpu.ready = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_controller.sv
// Self-checking bench for data_bus_controller: vector table, directed
// multi-cycle sequences, and randomized traffic against a memory-map model.
module tb_data_bus_controller;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_bus_if                          cpu ();
    slv_bus_if #(.AW(ROM_ADDR_WIDTH))   rom ();
    slv_bus_if #(.AW(RAM_ADDR_WIDTH))   ram ();
    slv_bus_if #(.AW(UART_ADDR_WIDTH))  uart ();

    data_bus_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu),
        .rom   (rom),
        .ram   (ram),
        .uart  (uart)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        cpu.req = req; cpu.we = we; cpu.addr = addr; cpu.wdata = wdata; cpu.be = be;
    endtask

    // rdy bits: [2]=rom [1]=ram [0]=uart
    task automatic slaves(input logic [2:0] rdy, input logic [31:0] rrd,
                          input logic [31:0] mrd, input logic [31:0] urd);
        rom.ready = rdy[2]; ram.ready = rdy[1]; uart.ready = rdy[0];
        rom.rdata = rrd;    ram.rdata = mrd;    uart.rdata = urd;
    endtask

    // ereq bits: [2]=rom [1]=ram [0]=uart
    task automatic expect_out(input string tag, input logic [2:0] ereq, input logic erdy,
                              input logic eerr, input logic [31:0] erd);
        chk({tag, ".reqs"},  {29'h0, rom.req, ram.req, uart.req}, {29'h0, ereq});
        chk({tag, ".ready"}, {31'h0, cpu.ready}, {31'h0, erdy});
        chk({tag, ".err"},   {31'h0, cpu.err},   {31'h0, eerr});
        chk({tag, ".rdata"}, cpu.rdata, erd);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  rdy;
        logic [31:0] rrd, mrd, urd;
        logic [2:0]  ereq;
        logic [31:0] eoff;
        logic        erdy;
        logic [31:0] erd;
        logic        eerr_next;
    } vec_t;

    function automatic vec_t mk(string n, logic we, logic [31:0] a, logic [2:0] rdy,
                                logic [31:0] rrd, logic [31:0] mrd, logic [31:0] urd,
                                logic [2:0] ereq, logic [31:0] eoff, logic erdy,
                                logic [31:0] erd, logic eerr);
        vec_t v;
        v.name = n; v.we = we; v.addr = a; v.rdy = rdy;
        v.rrd = rrd; v.mrd = mrd; v.urd = urd;
        v.ereq = ereq; v.eoff = eoff; v.erdy = erdy; v.erd = erd; v.eerr_next = eerr;
        return v;
    endfunction

    // Reference model: window membership by plain range arithmetic.
    // Returns 0=ROM 1=RAM 2=UART 3=unmapped.
    function automatic int ref_slave(logic [31:0] a);
        longint ua = longint'(a);
        if (ua >= longint'(ROM_BASE)  && ua < longint'(ROM_BASE)  + (64'd1 << ROM_ADDR_WIDTH))  return 0;
        if (ua >= longint'(RAM_BASE)  && ua < longint'(RAM_BASE)  + (64'd1 << RAM_ADDR_WIDTH))  return 1;
        if (ua >= longint'(UART_BASE) && ua < longint'(UART_BASE) + (64'd1 << UART_ADDR_WIDTH)) return 2;
        return 3;
    endfunction

    vec_t        vecs[9];
    logic [31:0] ram_word;

    initial begin
        vecs[0] = mk("rom_rd",      0, 32'h0000_0010, 3'b100, 32'h13, 0, 0,               3'b100, 32'h010, 1, 32'h13, 0);
        vecs[1] = mk("rom_stall",   0, 32'h0000_0FFC, 3'b011, 32'h55, 32'h66, 32'h77,     3'b100, 32'hFFC, 0, 32'h0, 0);
        vecs[2] = mk("ram_top",     0, 32'h1000_3FFC, 3'b111, 32'h11, 32'h1234_5678, 32'h22, 3'b010, 32'h3FFC, 1, 32'h1234_5678, 0);
        vecs[3] = mk("ram_past",    0, 32'h1000_4000, 3'b111, 1, 2, 3,                    3'b000, 0, 0, 0, 1);
        vecs[4] = mk("uart_wr",     1, 32'h2000_000C, 3'b001, 0, 0, 32'hAA,               3'b001, 32'hC, 1, 32'hAA, 0);
        vecs[5] = mk("uart_past",   0, 32'h2000_0010, 3'b111, 1, 2, 3,                    3'b000, 0, 0, 0, 1);
        vecs[6] = mk("rom_wr",      1, 32'h0000_0000, 3'b111, 1, 2, 3,                    3'b000, 0, 0, 0, 1);
        vecs[7] = mk("top_addr",    0, 32'hFFFF_FFFF, 3'b111, 1, 2, 3,                    3'b000, 0, 0, 0, 1);
        vecs[8] = mk("rom_past",    0, 32'h0000_1000, 3'b111, 1, 2, 3,                    3'b000, 0, 0, 0, 1);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive(1, 0, 32'h0000_0010, 0, 4'hF);
        slaves(3'b111, 32'h5, 32'h6, 32'h7);
        #12;
        expect_out("reset", 3'b000, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0);
        slaves(3'b000, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        expect_out("post_reset", 3'b000, 0, 0, 32'h0);

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(1, vecs[i].we, vecs[i].addr, 32'hDEAD_0000 + i, 4'hF);
            slaves(vecs[i].rdy, vecs[i].rrd, vecs[i].mrd, vecs[i].urd);
            #1;
            expect_out(vecs[i].name, vecs[i].ereq, vecs[i].erdy, 0, vecs[i].erd);
            if (vecs[i].ereq[2]) chk({vecs[i].name, ".off"}, {20'h0, rom.addr},  vecs[i].eoff);
            if (vecs[i].ereq[1]) chk({vecs[i].name, ".off"}, {18'h0, ram.addr},  vecs[i].eoff);
            if (vecs[i].ereq[0]) chk({vecs[i].name, ".off"}, {28'h0, uart.addr}, vecs[i].eoff);
            @(posedge clk); #1;
            if (vecs[i].eerr_next) expect_out({vecs[i].name, ".ack"}, 3'b000, 1, 1, 32'h0);
            @(negedge clk);
            drive(0, 0, 0, 0, 0);
            slaves(3'b000, 0, 0, 0);
            @(posedge clk); #1;
            expect_out({vecs[i].name, ".idle"}, 3'b000, 0, 0, 32'h0);
        end

        // ---------------- ROM read, ready one cycle later ----------------
        @(negedge clk);
        drive(1, 0, 32'h0000_0010, 0, 4'hF);
        slaves(3'b000, 32'h0, 0, 0);
        #1;
        expect_out("romseq.c0", 3'b100, 0, 0, 32'h0);
        chk("romseq.off", {20'h0, rom.addr}, 32'h010);
        @(negedge clk);
        slaves(3'b100, 32'h0000_0013, 0, 0);
        #1;
        expect_out("romseq.c1", 3'b100, 1, 0, 32'h0000_0013);
        @(negedge clk);
        drive(0, 0, 0, 0, 0); slaves(3'b000, 0, 0, 0);

        // ---------------- RAM write then read ----------------
        ram_word = 32'h0;
        @(negedge clk);
        drive(1, 1, 32'h1000_0004, 32'hCAFE_BABE, 4'b1111);
        slaves(3'b010, 0, 0, 0);
        #1;
        chk("ramwr.off", {18'h0, ram.addr}, 32'h4);
        chk("ramwr.req", {31'h0, ram.req}, 32'h1);
        chk("ramwr.ready", {31'h0, cpu.ready}, 32'h1);
        chk("ramwr.be", {28'h0, ram.be}, 32'hF);
        if (ram.req && ram.we) ram_word = ram.wdata;
        @(negedge clk);
        drive(1, 0, 32'h1000_0004, 32'h0, 4'b1111);
        slaves(3'b010, 0, ram_word, 0);
        #1;
        chk("ramrd.off", {18'h0, ram.addr}, 32'h4);
        expect_out("ramrd", 3'b010, 1, 0, 32'hCAFE_BABE);
        @(negedge clk);
        drive(0, 0, 0, 0, 0); slaves(3'b000, 0, 0, 0);

        // ---------------- UART stall for 3 cycles ----------------
        @(negedge clk);
        drive(1, 1, 32'h2000_0000, 32'h41, 4'b0001);
        slaves(3'b000, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            expect_out($sformatf("uart.stall%0d", c), 3'b001, 0, 0, 32'h0);
            chk("uart.wdata", uart.wdata, 32'h41);
            @(negedge clk);
        end
        slaves(3'b001, 0, 0, 32'h0);
        #1;
        expect_out("uart.done", 3'b001, 1, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0); slaves(3'b000, 0, 0, 0);

        // ---------------- reset while an error ack is pending ----------------
        @(negedge clk);
        drive(1, 0, 32'h3000_0000, 0, 4'hF);
        @(posedge clk); #1;
        expect_out("rstseq.ack", 3'b000, 1, 1, 32'h0);
        rst_n = 1'b0;
        #1;
        expect_out("rstseq.async", 3'b000, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            expect_out($sformatf("rstseq.after%0d", c), 3'b000, 0, 0, 32'h0);
        end

        // ---------------- randomized traffic vs. model ----------------
        begin
            logic ack_due;
            ack_due = 1'b0;
            for (int t = 0; t < 300; t++) begin
                logic [31:0] a, wd;
                logic        we;
                logic [3:0]  be;
                int          s, cyc;
                bit          done;
                case ($urandom % 5)
                    0: a = ROM_BASE  + ($urandom % (1 << ROM_ADDR_WIDTH));
                    1: a = RAM_BASE  + ($urandom % (1 << RAM_ADDR_WIDTH));
                    2: a = UART_BASE + ($urandom % (1 << UART_ADDR_WIDTH));
                    3: a = UART_BASE + (1 << UART_ADDR_WIDTH) + ($urandom % 4);
                    default: a = $urandom;
                endcase
                we = 1'($urandom % 2); wd = $urandom; be = 4'($urandom);
                s = ref_slave(a);
                done = 0;
                cyc = 0;
                while (!done && cyc < 20) begin
                    logic [2:0]  rdy;
                    logic [31:0] rrd, mrd, urd, erd;
                    logic [2:0]  ereq;
                    logic        erdy, eerr, bad_acc;
                    @(negedge clk);
                    drive(1, we, a, wd, be);
                    rdy = 3'($urandom); rrd = $urandom; mrd = $urandom; urd = $urandom;
                    slaves(rdy, rrd, mrd, urd);
                    #1;
                    bad_acc = (s == 3) || (s == 0 && we);
                    ereq = 3'b000;
                    if (s == 0 && !we) ereq = 3'b100;
                    if (s == 1)        ereq = 3'b010;
                    if (s == 2)        ereq = 3'b001;
                    erdy = 0; eerr = 0; erd = 0;
                    if (ack_due) begin
                        erdy = 1; eerr = 1;
                    end else if (!bad_acc) begin
                        erdy = rdy[2 - s];
                        if (erdy) erd = (s == 0) ? rrd : (s == 1) ? mrd : urd;
                    end
                    expect_out($sformatf("rnd%0d", t), ereq, erdy, eerr, erd);
                    if (s == 1) begin
                        chk("rnd.ramoff", {18'h0, ram.addr}, a - RAM_BASE);
                        chk("rnd.ramwd", ram.wdata, wd);
                        chk("rnd.rambe", {28'h0, ram.be}, {28'h0, be});
                        chk("rnd.ramwe", {31'h0, ram.we}, {31'h0, we});
                    end
                    if (s == 2) chk("rnd.uartoff", {28'h0, uart.addr}, a - UART_BASE);
                    if (s == 0 && !we) chk("rnd.romoff", {20'h0, rom.addr}, a - ROM_BASE);
                    ack_due = !ack_due && bad_acc;
                    done = erdy;
                    cyc++;
                    @(posedge clk);
                end
                if (!done) begin
                    total++; bad++;
                    $display("FAIL rnd%0d timeout: no ack after %0d cycles, want ack", t, cyc);
                    ack_due = 1'b0;
                end
                for (int g = 0; g < int'($urandom % 3); g++) begin
                    @(negedge clk);
                    drive(0, 0, 0, 0, 0);
                    slaves(3'b000, 0, 0, 0);
                    #1;
                    expect_out("rnd.gap", 3'b000, 0, 0, 32'h0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_bus_controller.md
Name: data_bus_controller

Overview:
- Routes the CPU core's single data-bus master port to three slaves: data port of the instruction ROM, data RAM, and UART.
- Address decode selects the slave, forwards the request with a base-relative offset, and muxes the response back.
- Unmapped accesses are answered locally with an error response so the core never hangs.
- Sits between core_cpu's data port and the memory/peripheral slaves in top.

Parameters:
- ROM_BASE, 32'h0000_0000, byte base address of ROM window
- ROM_ADDR_WIDTH, 12, byte-offset bits of ROM window (4 KiB)
- RAM_BASE, 32'h1000_0000, byte base address of RAM window
- RAM_ADDR_WIDTH, 14, byte-offset bits of RAM window (16 KiB)
- UART_BASE, 32'h2000_0000, byte base address of UART window
- UART_ADDR_WIDTH, 4, byte-offset bits of UART register window (16 B)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  master request valid; addr/we/wdata/be held stable until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_be  in  4  byte enables
- cpu_rdata  out  32  read data, valid when cpu_ready
- cpu_ready  out  1  transaction complete this cycle
- cpu_err  out  1  qualifies cpu_ready: unmapped access or write to ROM
- For each of rom_, ram_, uart_:
  - _req out 1
  - _we out 1
  - _addr out <X>_ADDR_WIDTH (byte offset)
  - _wdata out 32
  - _be out 4
  - _rdata in 32
  - _ready in 1

Behaviour:
- Decode (combinational): a slave is hit when `cpu_addr[31:W] == BASE[31:W]` for that slave's width W.
  - Windows must not overlap.
  - At most one hit.
  - No hit means unmapped.
- Forwarding:
  - `<x>_req = cpu_req & hit_x & rst_n`.
  - `_addr = cpu_addr[W-1:0]`.
  - `_we`, `_wdata`, `_be` are passed unchanged to all slaves.
  - Non-selected slaves see `req = 0`.
- ROM is read-only.
  - A write hitting ROM is not forwarded (`rom_req = 0`).
  - It is handled like an unmapped access (error path).
- Response:
  - `cpu_ready` and `cpu_rdata` are driven combinationally from the selected slave's `_ready` / `_rdata`.
  - The select comes from the current (held-stable) `cpu_addr`.
  - Slave latency, including multi-cycle UART stalls, passes through unchanged.
- Error path:
  - The register `err_q` is set in the cycle after `cpu_req` with an unmapped address or ROM write, while `err_q` is 0.
  - While `err_q` = 1: `cpu_ready` = 1, `cpu_err` = 1, `cpu_rdata` = 0.
  - `err_q` clears the next cycle.
  - Error-path latency is exactly 1 cycle; there are no back-to-back false acks.
- `cpu_err` = 0 on all normal completions.
- `cpu_rdata` = 0 whenever `cpu_ready` = 0.
- Reset (async assert, sync release):
  - `err_q` is cleared.
  - All slave `_req` are 0.
  - `cpu_ready`, `cpu_err` and `cpu_rdata` are 0.
- Reset asserted mid-transaction aborts it; no ack is issued after release unless `cpu_req` is re-presented.
- One outstanding transaction only; the master must not change address or data before `cpu_ready`.

Decomposition:
- Shared package `bus_pkg`:
  - memory-map constants (ROM_BASE, RAM_BASE, UART_BASE and their widths)
  - enum `bus_sel_t` {SEL_NONE, SEL_ROM, SEL_RAM, SEL_UART}
- One natural sub-module: `bus_addr_decoder` (pure combinational address to `bus_sel_t`, plus ROM-write error flag).

Test Plan:
- ROM read: `cpu_req`=1, `we`=0, `addr`=0x0000_0010; ROM returns `ready` next cycle with `rdata`=0x0000_0013.
  - Required: `rom_req`=1, `rom_addr`=0x010.
  - Required: `cpu_rdata`=0x0000_0013, `cpu_ready`=1, `cpu_err`=0.
  - Required: `ram_req`=`uart_req`=0.
- RAM write then read: write 0xCAFEBABE, `be`=4'b1111, to 0x1000_0004; then read the same address.
  - Required: `ram_addr`=0x0004 on both accesses; read returns 0xCAFEBABE.
- UART stall: write 0x41 to 0x2000_0000 while `uart_ready` is held low for 3 cycles.
  - Required: `cpu_ready` stays 0 for those 3 cycles, then pulses 1 in the same cycle as `uart_ready`.
- Unmapped read of 0x3000_0000.
  - Required: no slave `req`; next cycle `cpu_ready`=1, `cpu_err`=1, `cpu_rdata`=0, for exactly 1 cycle.
- ROM write to 0x0000_0000.
  - Required: `rom_req`=0; error ack after 1 cycle.
- Reset: assert `rst_n`=0 while an error ack is pending.
  - Required: `cpu_ready`=0 immediately (asynchronously); no ack after release with `cpu_req`=0.
